// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the memory-port arbiter.
// Default-configuration sizes are provided for code that does not carry its own parameters.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int ADDR_W_DEF    = 32;
    localparam int DATA_W_DEF    = 32;
    localparam int BURST_LEN_DEF = 4;

    localparam int BEAT_BYTES = DATA_W_DEF / 8;
    localparam int OFFSET_W   = $clog2(BURST_LEN_DEF * BEAT_BYTES);
    localparam int BEAT_CNT_W = $clog2(BURST_LEN_DEF);

    function automatic int calc_offset_w(input int data_w, input int burst_len);
        return $clog2(burst_len * (data_w / 8));
    endfunction

    function automatic int calc_cnt_w(input int burst_len);
        return $clog2(burst_len);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache and D-cache line bursts.
// Define ARB_DCACHE_PRIO_EN to give the D-cache fixed priority on simultaneous requests.
//
// state | meaning
// IDLE  | no burst; arbitrate pending requests and latch the winner's line
// BURST | issue beats to memory, advance on mem_ack
// DONE  | one-cycle done pulse to the owner, record it as last owner
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_rvalid,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wready,
    output logic              dc_rvalid,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int BEAT_SH = $clog2(DATA_W / 8);
    localparam int OFF_W   = calc_offset_w(DATA_W, BURST_LEN);
    localparam int CNT_W   = calc_cnt_w(BURST_LEN);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_owner_q, last_owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic              pick_d;

`ifdef ARB_DCACHE_PRIO_EN
    assign pick_d = dc_req;
`else
    // On a tie the requester that did not go last wins.
    assign pick_d = dc_req && (!ic_req || (last_owner_q == OWN_I));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_D;
            we_q         <= 1'b0;
            base_q       <= '0;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            base_q       <= base_d;
            beat_q       <= beat_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        base_d       = base_q;
        beat_d       = beat_q;
        case (state_q)
            IDLE: begin
                if (ic_req || dc_req) begin
                    state_d = BURST;
                    beat_d  = '0;
                    if (pick_d) begin
                        owner_d = OWN_D;
                        we_d    = dc_we;
                        base_d  = dc_addr & LINE_MASK;
                    end else begin
                        owner_d = OWN_I;
                        we_d    = 1'b0;
                        base_d  = ic_addr & LINE_MASK;
                    end
                end
            end
            BURST: begin
                if (mem_ack) begin
                    beat_d = beat_q + CNT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic in_burst;
    logic own_dc;
    logic beat_ok;

    assign in_burst = (state_q == BURST);
    assign own_dc   = (owner_q == OWN_D);
    assign beat_ok  = in_burst && mem_ack;

    assign mem_req   = in_burst;
    assign mem_we    = in_burst && we_q;
    assign mem_addr  = in_burst ? (base_q + (ADDR_W'(beat_q) << BEAT_SH)) : '0;
    assign mem_wdata = (in_burst && own_dc && we_q) ? dc_wdata : '0;

    assign ic_rvalid = beat_ok && !own_dc;
    assign dc_rvalid = beat_ok && own_dc && !we_q;
    assign dc_wready = beat_ok && own_dc && we_q;
    assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
    assign dc_rdata  = dc_rvalid ? mem_rdata : '0;

    assign ic_done = (state_q == DONE) && !own_dc;
    assign dc_done = (state_q == DONE) && own_dc;
    assign busy    = (state_q != IDLE);

endmodule
